// File: rtl/a2d_resp_pkg.sv
// Shared types and frame geometry for the A2D SPI responder.
package a2d_resp_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int CHNL_MSB   = 13;
    localparam int CHNL_LSB   = 11;
    localparam int CHNL_W     = CHNL_MSB - CHNL_LSB + 1;
    localparam int NUM_CHNL   = 1 << CHNL_W;
    localparam int CNT_W      = 5;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous pin plus a third flop for
// rise/fall detection on the synchronized level.
module sync_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1, r_s2, r_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
            r_s3 <= RST_VAL;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;
    assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder standing in for the ADC128S: returns the register-file value of
// the channel named in the previous frame. Define A2D_RESP_INV_DATA_EN to send data inverted.
module a2d_spi_resp
    import a2d_resp_pkg::*;
#(
    parameter int unsigned SCLK_MIN_HALF = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SS_n,
    input  logic                 SCLK,
    input  logic                 MOSI,
    output logic                 MISO,
    input  logic                 wr_en,
    input  logic [CHNL_W-1:0]    wr_chnl,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic [CHNL_W-1:0]    cmd_chnl,
    output logic                 frm_done,
    output logic                 frm_err
);

    localparam logic [7:0] MIN_HALF = 8'(SCLK_MIN_HALF);

    logic w_ss_lvl, w_ss_rise, w_ss_fall;
    logic w_unused_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic r_mosi_s1, r_mosi_s2;

    // Idle levels: SS_n deselected high, SCLK low, so reset never fakes an edge.
    sync_edge_det #(.RST_VAL(1'b1)) u_ss_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (SS_n),
        .o_level (w_ss_lvl),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    sync_edge_det #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (SCLK),
        .o_level (w_unused_sclk_lvl),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_mosi_s1 <= MOSI;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    logic [DATA_BITS-1:0] r_regs [NUM_CHNL];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHNL; i++) r_regs[i] <= '0;
        end else if (wr_en) begin
            r_regs[wr_chnl] <= wr_data;
        end
    end

    state_t                  r_state;
    logic [FRAME_BITS-1:0]   r_tx;
    logic [CHNL_MSB:0]       r_rx;
    logic [CNT_W-1:0]        r_cnt;
    logic [CHNL_W-1:0]       r_cmd_chnl;
    logic                    r_frm_done, r_frm_err;
    logic [FRAME_BITS-1:0]   w_load_word;

`ifdef A2D_RESP_INV_DATA_EN
    assign w_load_word = {{(FRAME_BITS-DATA_BITS){1'b0}}, ~r_regs[r_cmd_chnl]};
`else
    assign w_load_word = {{(FRAME_BITS-DATA_BITS){1'b0}}, r_regs[r_cmd_chnl]};
`endif

    // rx only keeps the bits up to the channel field; older bits fall off the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx       <= '0;
            r_rx       <= '0;
            r_cnt      <= '0;
            r_cmd_chnl <= '0;
            r_frm_done <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            r_frm_done <= 1'b0;
            r_frm_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ss_fall) begin
                        r_state <= SHIFT;
                        r_tx    <= w_load_word;
                        r_cnt   <= '0;
                        r_rx    <= '0;
                    end
                end
                SHIFT: begin
                    if (w_ss_rise) begin
                        r_state <= FINISH;
                    end else begin
                        if (w_sclk_rise) begin
                            r_rx <= {r_rx[CHNL_MSB-1:0], r_mosi_s2};
                            if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
                        end
                        if (w_sclk_fall) r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                    if (r_cnt == CNT_FULL) begin
                        r_cmd_chnl <= r_rx[CHNL_MSB:CHNL_LSB];
                        r_frm_done <= 1'b1;
                    end else begin
                        r_frm_err  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // MISO is quiet as soon as the synchronized select goes high.
    assign MISO     = (r_state == SHIFT) & ~w_ss_lvl & r_tx[FRAME_BITS-1];
    assign cmd_chnl = r_cmd_chnl;
    assign frm_done = r_frm_done;
    assign frm_err  = r_frm_err;

    logic [7:0] r_half_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_half_cnt <= '1;
        end else begin
            if (r_state == SHIFT && (w_sclk_rise || w_sclk_fall))
                assert (r_half_cnt >= MIN_HALF);
            if (w_sclk_rise || w_sclk_fall) r_half_cnt <= 8'd1;
            else if (r_half_cnt != '1)      r_half_cnt <= r_half_cnt + 8'd1;
        end
    end

endmodule

// File: doc/a2d_spi_resp.md
# a2d_spi_resp

- **Function:** synthesizable SPI responder (slave) for the A2D path. It answers the 16-bit A2D SPI frames issued by the A2D interface master.
- **Usage:** stands in for the external ADC128S when the A2D path is prototyped on-chip or in FPGA emulation.
- **Frame handling:** decodes the requested channel from each command frame. The 12-bit value for the channel requested in the *previous* frame is returned on MISO (one-frame pipeline).
- **Data source:** per-channel values come from an 8-entry register file loaded by local logic.

## Interface
Parameters:
- SCLK_MIN_HALF, 4, minimum SCLK half-period in clk cycles the block is guaranteed to track (documentation/assertion only)

Ports:
- clk  input  1  system clock; all logic on posedge
- rst  input  1  reset, asynchronous, active-high
- SS_n  input  1  SPI select, active-low, asynchronous to clk
- SCLK  input  1  SPI clock from master, asynchronous to clk
- MOSI  input  1  command data from master
- MISO  output  1  response data to master
- wr_en  input  1  register-file write strobe
- wr_chnl  input  3  register-file write address
- wr_data  input  12  register-file write data
- cmd_chnl  output  3  channel decoded from last valid frame
- frm_done  output  1  one-clk pulse, valid 16-bit frame completed
- frm_err  output  1  one-clk pulse, frame aborted or overlong

## Operation
- **Input synchronization:** SS_n, SCLK and MOSI each pass through a 2-flop synchronizer. A third flop on SS_n and SCLK gives rise/fall edge detection.
- **FSM states:** IDLE, SHIFT, FINISH.
  - IDLE -> SHIFT on SS_n fall. Load tx shift register with {4'h0, regs[cmd_chnl]}, clear bit counter (5 bits), clear rx shift register.
  - SHIFT, on SCLK rise: shift synchronized MOSI into rx LSB; increment counter, saturating at 17.
  - SHIFT, on SCLK fall: shift tx left. MISO = tx[15] at all times in SHIFT.
  - SHIFT -> FINISH on SS_n rise.
  - FINISH -> IDLE always, after one clk:
    - counter == 16: cmd_chnl <= rx[13:11], pulse frm_done.
    - otherwise: pulse frm_err, cmd_chnl unchanged.
- **Command format:** {2'b00, chnl[2:0], 11'h000} MSB first. Bits other than [13:11] are ignored.
- **MISO outside SHIFT:** driven 0.
- **Register file:** written when wr_en is high, any state. On a same-cycle write and frame load to the same entry, the load takes the pre-write value.
- **Reset behaviour:**
  - Outputs: MISO=0, cmd_chnl=0, frm_done=0, frm_err=0.
  - Internal: regs all 0, state IDLE, counter 0.
  - Reset mid-frame abandons the frame with no pulse. The block resynchronizes on the next SS_n fall.
  - SCLK edges seen while in IDLE are ignored.

## Timing
- **Synchronizer latency:** 2–3 clk from pin to synchronized level. Edge detect adds 1 clk.
- **SCLK half-period:** must be ≥ SCLK_MIN_HALF clk. The A2D master's SCLK (clk/32) satisfies this.
- **Bit presentation:**
  - MISO bit 15 is valid ≤ 4 clk after the SS_n fall, i.e. before the first SCLK rise.
  - Each subsequent bit is valid ≤ 4 clk after the SCLK fall at the pin.
- **Frame-end pulses:** frm_done and frm_err are high exactly one clk, 4–5 clk after the SS_n rise at the pin.
- **cmd_chnl:** updates in the same cycle as frm_done.
- **Back-to-back frames:** SS_n high time ≥ 6 clk is required. Shorter gaps are undefined.

## Configuration
- A2D_RESP_INV_DATA_EN defined: the 12 data bits are loaded inverted ({4'h0, ~regs[cmd_chnl]}), matching the inverted-result convention of the ADC128S model.
- Not defined: data is transmitted true. The 4'h0 header is never inverted.

## Structure
- **Package a2d_resp_pkg:**
  - FSM state enum.
  - FRAME_BITS=16, DATA_BITS=12, CHNL_MSB=13, CHNL_LSB=11.
- **Sub-module sync_edge_det:** 2-flop synchronizer plus edge flop, outputs level/rise/fall. Instantiated for SS_n and SCLK. MOSI uses the synchronizer path only.

## Test plan
- **Pipelined readback:** write regs[3]=12'hA5C, regs[5]=12'h3F0. Frame chnl=3, then frame chnl=5.
  - Frame 2 returns 16'h0A5C.
  - Frame 3 returns 16'h03F0.
  - frm_done pulses once per frame; cmd_chnl 3 then 5.
- **Full channel sweep:** load regs[i]=12'h111*i+1 and sweep all 8 channels through the master. Each returned value matches, or its inverse with A2D_RESP_INV_DATA_EN defined.
- **Aborted frame:** raise SS_n after 9 SCLK rises.
  - Response: one frm_err pulse, no frm_done, cmd_chnl unchanged.
  - The next full frame returns data for the prior valid channel.
- **Overlong frame:** 17 SCLK rises -> frm_err, cmd_chnl unchanged.
- **Write collision:** write regs[2]=12'hFFF in the same clk the frame loads for channel 2 -> that frame returns the old value; the following frame returns 12'hFFF.
- **Reset mid-frame:** assert rst after 6 bits.
  - MISO, cmd_chnl, frm_done and frm_err are all 0 within the rst cycle.
  - A subsequent frame chnl=0 completes with frm_done and returns 16'h0000.
